// File: rtl/axi4_addr_map_pkg.sv
// System slave map, per-master permission table and shared types for the
// AXI4 write-address access checker.
package axi4_addr_map_pkg;

  localparam int unsigned MAP_ADDR_W  = 64;
  localparam int unsigned MAP_SLAVES  = 4;
  localparam int unsigned MAP_MASTERS = 4;

  // Index i holds slave i (S0 is the rightmost entry).
  localparam logic [MAP_SLAVES-1:0][MAP_ADDR_W-1:0] SLAVE_BASE = {
    64'h0000_0020_0000_0000,
    64'h0000_0010_0000_0000,
    64'h0000_0000_0000_0000,
    64'h0000_0100_0000_0000
  };

  localparam logic [MAP_SLAVES-1:0][MAP_ADDR_W-1:0] SLAVE_SIZE = {
    64'h0000_0000_0000_1000,
    64'h0000_0000_0010_0000,
    64'h0000_0000_0002_0000,
    64'h0000_0008_0000_0000
  };

  // Row m is master m; bit i grants access to slave i.
  localparam logic [MAP_MASTERS-1:0][MAP_SLAVES-1:0] PERM_MASK = {
    4'b1001,
    4'b0101,
    4'b0101,
    4'b1101
  };

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/axi4_addr_decoder.sv
// Combinational start-address decode against the slave map, qualified by the
// permission row of the requesting master.
module axi4_addr_decoder #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic [ADDR_W-1:0]     addr,
  input  logic [1:0]            master_idx,
  output logic [NUM_SLAVES-1:0] hit_onehot_c,
  output logic                  allowed_c
);
  import axi4_addr_map_pkg::*;

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [SUM_W-1:0]      addr_ext;
  logic [NUM_SLAVES-1:0] perm_row;

  assign addr_ext = SUM_W'(addr);
  assign perm_row = NUM_SLAVES'(PERM_MASK[master_idx]);

  // One extra bit keeps base+size from wrapping for slaves at the top of the map.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    localparam logic [SUM_W-1:0] LO = SUM_W'(SLAVE_BASE[g]);
    localparam logic [SUM_W-1:0] HI = SUM_W'(SLAVE_BASE[g]) + SUM_W'(SLAVE_SIZE[g]);
    logic lo_ok;
    if (SLAVE_BASE[g] == '0) begin : g_zero_base
      assign lo_ok = 1'b1;
    end else begin : g_base
      assign lo_ok = (addr_ext >= LO);
    end
    assign hit_onehot_c[g] = lo_ok && (addr_ext < HI);
  end

  assign allowed_c = |(hit_onehot_c & perm_row);

endmodule

// File: rtl/axi4_addr_access_checker.sv
// Per-master AW gate: forwards permitted bursts with a one-hot slave select,
// terminates denied/unmapped bursts locally with a W drain and DECERR response.
module axi4_addr_access_checker #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned MASTER_IDX = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [ID_W-1:0]       s_awid,
  input  logic [7:0]            s_awlen,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [ID_W-1:0]       s_bid,
  output logic [1:0]            s_bresp,
  output logic                  w_drain,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [NUM_SLAVES-1:0] m_aw_sel,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [ID_W-1:0]       m_awid,
  output logic [7:0]            m_awlen,
  output logic [15:0]           err_count
);
  import axi4_addr_map_pkg::*;

  localparam logic [1:0]  MIDX    = 2'(MASTER_IDX);
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  chk_state_e state_q, state_d;

  logic                  awready_q, awready_d;
  logic                  drain_q, drain_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  fwd_q, fwd_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [15:0]           err_q, err_d;

  logic [NUM_SLAVES-1:0] hit_onehot_c;
  logic                  allowed_c;
  logic                  aw_fire_c;

  axi4_addr_decoder #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decoder (
    .addr         (s_awaddr),
    .master_idx   (MIDX),
    .hit_onehot_c (hit_onehot_c),
    .allowed_c    (allowed_c)
  );

  // awready_q is low in the first post-reset cycle, so it gates the accept too.
  assign aw_fire_c = s_awvalid && awready_q;

  // Next-state and next-output decode; every output register mirrors state_d.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    sel_d     = sel_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (aw_fire_c) begin
          addr_d = s_awaddr;
          id_d   = s_awid;
          len_d  = s_awlen;
          if (allowed_c) begin
            sel_d   = hit_onehot_c;
            state_d = ST_FWD;
          end else begin
            sel_d   = '0;
            state_d = ST_DRAIN;
            if (err_q != ERR_MAX) begin
              err_d = err_q + 16'd1;
            end
          end
        end
      end
      ST_FWD: begin
        if (fwd_q && m_awready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q && s_wvalid && s_wlast) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bvalid_q && s_bready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awready_d = (state_d == ST_IDLE);
    fwd_d     = (state_d == ST_FWD);
    drain_d   = (state_d == ST_DRAIN);
    bvalid_d  = (state_d == ST_RESP);
    bresp_d   = (state_d == ST_RESP) ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      fwd_q     <= 1'b0;
      drain_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      sel_q     <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      err_q     <= '0;
    end else begin
      awready_q <= awready_d;
      fwd_q     <= fwd_d;
      drain_q   <= drain_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = drain_q;
  assign w_drain   = drain_q;
  assign s_bvalid  = bvalid_q;
  assign s_bid     = id_q;
  assign s_bresp   = bresp_q;
  assign m_awvalid = fwd_q;
  assign m_aw_sel  = sel_q;
  assign m_awaddr  = addr_q;
  assign m_awid    = id_q;
  assign m_awlen   = len_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_axi4_addr_access_checker.sv
// Directed bench: one checker instance per master row, driven independently,
// with hand-computed decode/permission outcomes.
module tb_axi4_addr_access_checker;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned NS     = 4;
  localparam int unsigned NM     = 4;

  logic aclk;
  logic aresetn;

  logic [NM-1:0]             awvalid, awready, wvalid, wready, wlast;
  logic [NM-1:0]             bvalid, bready, drain, m_awvalid, m_awready;
  logic [NM-1:0][ADDR_W-1:0] awaddr, m_awaddr;
  logic [NM-1:0][ID_W-1:0]   awid, bid, m_awid;
  logic [NM-1:0][7:0]        awlen, m_awlen;
  logic [NM-1:0][1:0]        bresp;
  logic [NM-1:0][NS-1:0]     sel;
  logic [NM-1:0][15:0]       errc;

  int n_checks;
  int n_pass;
  logic [15:0] exp_err [NM];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  for (genvar g = 0; g < NM; g++) begin : g_m
    axi4_addr_access_checker #(
      .ADDR_W     (ADDR_W),
      .ID_W       (ID_W),
      .NUM_SLAVES (NS),
      .MASTER_IDX (g)
    ) u_dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_awvalid (awvalid[g]),
      .s_awready (awready[g]),
      .s_awaddr  (awaddr[g]),
      .s_awid    (awid[g]),
      .s_awlen   (awlen[g]),
      .s_wvalid  (wvalid[g]),
      .s_wready  (wready[g]),
      .s_wlast   (wlast[g]),
      .s_bvalid  (bvalid[g]),
      .s_bready  (bready[g]),
      .s_bid     (bid[g]),
      .s_bresp   (bresp[g]),
      .w_drain   (drain[g]),
      .m_awvalid (m_awvalid[g]),
      .m_awready (m_awready[g]),
      .m_aw_sel  (sel[g]),
      .m_awaddr  (m_awaddr[g]),
      .m_awid    (m_awid[g]),
      .m_awlen   (m_awlen[g]),
      .err_count (errc[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_cleared(input int m);
    check("rst_wready",  64'(wready[m]),    64'd0);
    check("rst_bvalid",  64'(bvalid[m]),    64'd0);
    check("rst_bid",     64'(bid[m]),       64'd0);
    check("rst_bresp",   64'(bresp[m]),     64'd0);
    check("rst_drain",   64'(drain[m]),     64'd0);
    check("rst_mvalid",  64'(m_awvalid[m]), 64'd0);
    check("rst_sel",     64'(sel[m]),       64'd0);
    check("rst_maddr",   64'(m_awaddr[m]),  64'd0);
    check("rst_mid",     64'(m_awid[m]),    64'd0);
    check("rst_mlen",    64'(m_awlen[m]),   64'd0);
    check("rst_errc",    64'(errc[m]),      64'd0);
  endtask

  task automatic allow_txn(input int m, input logic [63:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [3:0] exp_sel, input int stall);
    awvalid[m] = 1'b1; awaddr[m] = addr; awid[m] = id; awlen[m] = len;
    check("fwd_awready_idle", 64'(awready[m]), 64'd1);
    tick();
    awvalid[m] = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      check("fwd_mvalid",  64'(m_awvalid[m]), 64'd1);
      check("fwd_sel",     64'(sel[m]),       64'(exp_sel));
      check("fwd_addr",    m_awaddr[m],       addr);
      check("fwd_id",      64'(m_awid[m]),    64'(id));
      check("fwd_len",     64'(m_awlen[m]),   64'(len));
      check("fwd_awready", 64'(awready[m]),   64'd0);
      check("fwd_drain",   64'(drain[m]),     64'd0);
      if (i == stall) m_awready[m] = 1'b1;
      tick();
    end
    m_awready[m] = 1'b0;
    check("fwd_done_mvalid",  64'(m_awvalid[m]), 64'd0);
    check("fwd_done_awready", 64'(awready[m]),   64'd1);
    check("fwd_errc",         64'(errc[m]),      64'(exp_err[m]));
  endtask

  task automatic deny_txn(input int m, input logic [63:0] addr, input logic [3:0] id,
                          input int nbeats, input int bwait);
    awvalid[m] = 1'b1; awaddr[m] = addr; awid[m] = id; awlen[m] = 8'(nbeats - 1);
    check("deny_awready_idle", 64'(awready[m]), 64'd1);
    tick();
    awvalid[m] = 1'b0;
    if (exp_err[m] != 16'hFFFF) exp_err[m] = exp_err[m] + 16'd1;
    check("deny_drain",  64'(drain[m]),     64'd1);
    check("deny_mvalid", 64'(m_awvalid[m]), 64'd0);
    check("deny_errc",   64'(errc[m]),      64'(exp_err[m]));
    for (int b = 0; b < nbeats; b++) begin
      wvalid[m] = 1'b1;
      wlast[m]  = (b == nbeats - 1);
      check("drain_wready", 64'(wready[m]), 64'd1);
      check("drain_bvalid", 64'(bvalid[m]), 64'd0);
      tick();
    end
    wvalid[m] = 1'b0; wlast[m] = 1'b0;
    check("resp_drain", 64'(drain[m]), 64'd0);
    for (int i = 0; i <= bwait; i++) begin
      check("resp_bvalid",  64'(bvalid[m]),  64'd1);
      check("resp_bid",     64'(bid[m]),     64'(id));
      check("resp_bresp",   64'(bresp[m]),   64'd3);
      check("resp_awready", 64'(awready[m]), 64'd0);
      check("resp_wready",  64'(wready[m]),  64'd0);
      if (i == bwait) bready[m] = 1'b1;
      tick();
    end
    bready[m] = 1'b0;
    check("resp_done_bvalid",  64'(bvalid[m]),  64'd0);
    check("resp_done_awready", 64'(awready[m]), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    aresetn  = 1'b0;
    awvalid = '0; awaddr = '0; awid = '0; awlen = '0;
    wvalid = '0; wlast = '0; bready = '0; m_awready = '0;
    for (int m = 0; m < NM; m++) exp_err[m] = 16'd0;

    #12;
    for (int m = 0; m < NM; m++) begin
      check("rst_awready", 64'(awready[m]), 64'd0);
      check_cleared(m);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    for (int m = 0; m < NM; m++) check("post_rst_awready", 64'(awready[m]), 64'd1);

    // M0 to S3, held 5 cycles by crossbar backpressure
    allow_txn(0, 64'h0000_0020_0000_0010, 4'h3, 8'd3, 4'b1000, 5);
    // M1 to S3 is not permitted
    deny_txn(1, 64'h0000_0020_0000_0000, 4'h5, 3, 0);
    // M0: unmapped hole, then the S0 upper boundary on both sides
    deny_txn(0, 64'h0000_0000_0100_0000, 4'h2, 1, 0);
    allow_txn(0, 64'h0000_0107_FFFF_FFFF, 4'h1, 8'd0, 4'b0001, 0);
    deny_txn(0, 64'h0000_0108_0000_0000, 4'h7, 2, 0);
    // M2 to S2 is permitted
    allow_txn(2, 64'h0000_0010_0000_0000, 4'h9, 8'd0, 4'b0100, 1);
    // M3 to the boot ROM with a slow B acceptor
    deny_txn(3, 64'h0, 4'hA, 1, 4);

    // Reset in the middle of a 4-beat drain on M2
    awvalid[2] = 1'b1; awaddr[2] = 64'h0; awid[2] = 4'h6; awlen[2] = 8'd3;
    tick();
    awvalid[2] = 1'b0;
    check("mid_drain", 64'(drain[2]), 64'd1);
    wvalid[2] = 1'b1; wlast[2] = 1'b0;
    tick();
    aresetn = 1'b0;
    #1;
    wvalid[2] = 1'b0;
    for (int m = 0; m < NM; m++) exp_err[m] = 16'd0;
    check("mid_rst_awready", 64'(awready[2]), 64'd0);
    check_cleared(2);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    check("mid_post_awready", 64'(awready[2]), 64'd1);
    check("mid_post_bvalid",  64'(bvalid[2]),  64'd0);
    allow_txn(2, 64'h0000_0100_0000_0040, 4'hC, 8'd7, 4'b0001, 1);

    // Saturation on M3: count one burst, then preload near the top to keep runtime short
    deny_txn(3, 64'h0000_0020_0000_0000 - 64'h1, 4'h4, 1, 0);
    force g_m[3].u_dut.err_q = 16'hFFFD;
    tick();
    release g_m[3].u_dut.err_q;
    #1;
    check("sat_preload", 64'(errc[3]), 64'hFFFD);
    exp_err[3] = 16'hFFFD;
    deny_txn(3, 64'h0, 4'h1, 1, 0);
    deny_txn(3, 64'h0, 4'h2, 2, 0);
    deny_txn(3, 64'h0, 4'h3, 1, 0);
    check("sat_final", 64'(errc[3]), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_addr_access_checker.md
# axi4_addr_access_checker

Per-master write-address gate at the upstream edge of the AXI4 interconnect. It decodes each AW address against the system slave map and checks the result against that master's permission mask. Permitted bursts are forwarded to the crossbar with a one-hot slave select. Denied or unmapped bursts are terminated locally: the block drains their W beats and returns a DECERR write response.

## Interface
Parameters:
- ADDR_W, 64, address width
- ID_W, 4, AXI ID width
- NUM_SLAVES, 4, slave count
- MASTER_IDX, 0, row of the permission table this instance enforces (0..3)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_awvalid  in  1  master AW valid
- s_awready  out  1  master AW ready
- s_awaddr  in  ADDR_W  AW address
- s_awid  in  ID_W  AW ID
- s_awlen  in  8  AW burst length minus 1
- s_wvalid  in  1  master W valid
- s_wready  out  1  W ready; driven only while draining
- s_wlast  in  1  W last beat
- s_bvalid  out  1  error B valid
- s_bready  in  1  B ready
- s_bid  out  ID_W  error B ID
- s_bresp  out  2  error B response
- w_drain  out  1  high while this block owns the W channel; the crossbar W mux yields on it
- m_awvalid  out  1  forwarded AW valid
- m_awready  in  1  crossbar AW ready
- m_aw_sel  out  NUM_SLAVES  one-hot target slave
- m_awaddr  out  ADDR_W  registered address
- m_awid  out  ID_W  registered ID
- m_awlen  out  8  registered length
- err_count  out  16  saturating count of denied bursts

## Operation
- FSM states: IDLE, FWD, DRAIN, RESP.
- IDLE: s_awready=1. On s_awvalid, capture addr/id/len and register the decode result.
  - Allowed: go to FWD.
  - Denied: go to DRAIN and increment err_count, saturating at 16'hFFFF.
- Decode: slave i hits when base_i <= addr < base_i+size_i. Compute the comparison with an ADDR_W+1-bit sum so the upper bound cannot wrap.
  - At most one slave hits.
  - No hit counts as unmapped and is denied.
  - A hit on slave i is allowed only if perm[MASTER_IDX][i]=1.
  - Only the start address is checked.
- FWD: m_awvalid=1 with the registered payload and m_aw_sel. The payload is held stable until m_awready, then the FSM returns to IDLE.
- DRAIN: w_drain=1, s_wready=1, W data discarded. On s_wvalid && s_wlast, go to RESP.
  - Beat count is not checked against awlen; WLAST alone terminates the drain.
- RESP: s_bvalid=1, s_bid=captured ID, s_bresp=2'b11 (DECERR). Held until s_bready, then the FSM returns to IDLE.
- Only one transaction is in flight; no new AW is accepted outside IDLE.

## Timing
- Reset (async assert, sync deassert at aclk):
  - FSM to IDLE.
  - s_awready=0 during reset, 1 in the first cycle after release.
  - All other outputs 0: s_wready, s_bvalid, s_bid, s_bresp, w_drain, m_awvalid, m_aw_sel, m_awaddr, m_awid, m_awlen, err_count.
- AW accepted at edge N:
  - Allowed: m_awvalid is high in cycle N+1.
  - Denied: w_drain and s_wready are high in cycle N+1.
- A W beat with WLAST accepted at edge M drives s_bvalid high in cycle M+1.
- B handshake at edge K: s_awready is 1 in cycle K+1. Same for m_awready in FWD.
- All outputs are registered or decoded from state; there are no combinational in→out paths except in the IDLE accept decode.
- Reset mid-burst abandons the transaction silently; no B is issued.

## Structure
- A shared package (axi4_addr_map_pkg) holds:
  - Slave base/size constant arrays:
    - S0 0x0000_0100_0000_0000/0x8_0000_0000
    - S1 0x0/0x2_0000
    - S2 0x0000_0010_0000_0000/0x10_0000
    - S3 0x0000_0020_0000_0000/0x1000
  - Permission masks, bit i = slave i: M0=4'b1101, M1=4'b0101, M2=4'b0101, M3=4'b1001.
  - RESP_DECERR=2'b11.
  - FSM state enum.
- One sub-module: axi4_addr_decoder. It is combinational and maps address + master index to {hit_onehot, allowed}.

## Test plan
- M0, awaddr=0x0000_0020_0000_0010, len=3 -> m_awvalid at N+1, m_aw_sel=4'b1000. Payload holds through 5 cycles of m_awready=0. err_count stays 0.
- M1, awaddr=0x0000_0020_0000_0000, id=5, len=2 -> 3 W beats drained with s_wready=1, then B id=5 resp=2'b11. No m_awvalid. err_count=1.
- M0, awaddr=0x0000_0000_0100_0000 (unmapped) -> DECERR. Boundary: 0x0000_0107_FFFF_FFFF allowed for S0; 0x0000_0108_0000_0000 denied.
- M3, awaddr=0x0 (Boot_ROM) -> DECERR. s_bready held low 4 cycles: s_bvalid and s_bid stay stable, s_awready stays 0.
- aresetn asserted mid-DRAIN after beat 1 of 4 -> all outputs 0 immediately. After release, s_awready=1 and a new allowed AW forwards normally.
- 65 536 denied bursts -> err_count saturates at 0xFFFF.
